// File: rtl/sp_pkg.sv
// Shared SPCore operand-fetch definitions: widths, instruction layout, flags, ALU opcodes.
package sp_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned REG_AW  = 4;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned NREGS   = 16;
    localparam int unsigned INSTR_W = 24;

    // Instruction field LSB positions within the 24-bit word
    localparam int unsigned OP_LSB   = 20;
    localparam int unsigned RD_LSB   = 16;
    localparam int unsigned RA_LSB   = 12;
    localparam int unsigned RB_LSB   = 8;
    localparam int unsigned RC_LSB   = 4;
    localparam int unsigned RSVD_BIT = 3;

    localparam int unsigned GUARD = 0;
    localparam int unsigned WR_EN = 1;
    localparam int unsigned SET_P = 2;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [OP_W-1:0]   op_t;

    typedef struct packed {
        op_t       op;
        reg_addr_t rd;
        reg_addr_t ra;
        reg_addr_t rb;
        reg_addr_t rc;
        logic      rsvd;
        logic      set_p;
        logic      wr_en;
        logic      guard;
    } instr_t;

    localparam op_t OP_ADD = 4'h0;
    localparam op_t OP_SUB = 4'h1;
    localparam op_t OP_AND = 4'h2;
    localparam op_t OP_OR  = 4'h3;
    localparam op_t OP_XOR = 4'h4;
    localparam op_t OP_CMP = 4'h5;
    localparam op_t OP_MAC = 4'h6;

    // Source operand select: r0 is zero, a same-edge commit to src wins over the file
    function automatic data_t fwd_mux(input reg_addr_t src, input data_t rf_val,
                                      input logic fwd_en, input reg_addr_t fwd_rd,
                                      input data_t fwd_val);
        data_t res;
        if (src == '0)                        res = '0;
        else if (fwd_en && (fwd_rd == src))   res = fwd_val;
        else                                  res = rf_val;
        return res;
    endfunction

endpackage

// File: rtl/sp_operand_fetch_if.sv
// Instruction handshake plus ALU issue/result bus between decode, operand fetch and ALU.
interface sp_operand_fetch_if;
    import sp_pkg::*;

    logic   in_valid;
    logic   in_ready;
    instr_t in_instr;
    data_t  alu_a;
    data_t  alu_b;
    data_t  alu_c;
    op_t    alu_op;
    logic   ex_valid;
    data_t  alu_out;
    logic   alu_p;

    modport master (
        output in_valid, in_instr, alu_out, alu_p,
        input  in_ready, alu_a, alu_b, alu_c, alu_op, ex_valid
    );

    modport slave (
        input  in_valid, in_instr, alu_out, alu_p,
        output in_ready, alu_a, alu_b, alu_c, alu_op, ex_valid
    );

endinterface

// File: rtl/sp_regfile.sv
// 16-entry register file: three operand read ports, one debug port, one write port, r0 = 0.
module sp_regfile
    import sp_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    input  reg_addr_t ra_addr,
    input  reg_addr_t rb_addr,
    input  reg_addr_t rc_addr,
    input  reg_addr_t dbg_addr,
    output data_t     ra_data,
    output data_t     rb_data,
    output data_t     rc_data,
    output data_t     dbg_data,
    input  logic      we,
    input  reg_addr_t waddr,
    input  data_t     wdata
);

    data_t regs [NREGS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data  = (ra_addr  == '0) ? '0 : regs[ra_addr];
    assign rb_data  = (rb_addr  == '0) ? '0 : regs[rb_addr];
    assign rc_data  = (rc_addr  == '0) ? '0 : regs[rc_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/sp_operand_fetch.sv
// SPCore operand fetch/issue stage: S1 issue register, forwarding, predicate and retire count.
module sp_operand_fetch
    import sp_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    sp_operand_fetch_if.slave     bus,
    input  logic                  hold,
    output logic                  pred,
    output logic [DATA_W-1:0]     retired,
    input  logic [REG_AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    logic      s1_exec;
    reg_addr_t s1_rd;
    logic      s1_wr_en;
    logic      s1_set_p;

    logic      accept_c;
    logic      commit_c;
    logic      fwd_wr_c;
    logic      fwd_p_c;
    logic      p_eff_c;
    logic      exec_c;
    data_t     rf_a_c, rf_b_c, rf_c_c;
    data_t     opnd_a_c, opnd_b_c, opnd_c_c;
    instr_t    instr_c;
    logic      unused_rsvd;

    assign instr_c     = bus.in_instr;
    assign unused_rsvd = instr_c.rsvd;
    assign bus.in_ready = !hold;

    sp_regfile u_rf (
        .clock    (clock),
        .reset_n  (reset_n),
        .ra_addr  (instr_c.ra),
        .rb_addr  (instr_c.rb),
        .rc_addr  (instr_c.rc),
        .dbg_addr (dbg_addr),
        .ra_data  (rf_a_c),
        .rb_data  (rf_b_c),
        .rc_data  (rf_c_c),
        .dbg_data (dbg_data),
        .we       (fwd_wr_c),
        .waddr    (s1_rd),
        .wdata    (bus.alu_out)
    );

    // Commit of the S1 instruction happens on this edge; its results bypass into the accept
    always_comb begin
        accept_c = bus.in_valid && !hold;
        commit_c = bus.ex_valid && s1_exec && !hold;
        fwd_wr_c = commit_c && s1_wr_en && (s1_rd != '0);
        fwd_p_c  = commit_c && s1_set_p;
        p_eff_c  = fwd_p_c ? bus.alu_p : pred;
        exec_c   = !instr_c.guard || p_eff_c;
        opnd_a_c = fwd_mux(instr_c.ra, rf_a_c, fwd_wr_c, s1_rd, bus.alu_out);
        opnd_b_c = fwd_mux(instr_c.rb, rf_b_c, fwd_wr_c, s1_rd, bus.alu_out);
        opnd_c_c = fwd_mux(instr_c.rc, rf_c_c, fwd_wr_c, s1_rd, bus.alu_out);
    end

    // S1 issue register; alu_* keep their last values across bubbles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_c    <= '0;
            bus.alu_op   <= '0;
            bus.ex_valid <= 1'b0;
            s1_exec      <= 1'b0;
            s1_rd        <= '0;
            s1_wr_en     <= 1'b0;
            s1_set_p     <= 1'b0;
        end else if (!hold) begin
            bus.ex_valid <= accept_c;
            if (accept_c) begin
                bus.alu_a  <= opnd_a_c;
                bus.alu_b  <= opnd_b_c;
                bus.alu_c  <= opnd_c_c;
                bus.alu_op <= instr_c.op;
                s1_exec    <= exec_c;
                s1_rd      <= instr_c.rd;
                s1_wr_en   <= instr_c.wr_en;
                s1_set_p   <= instr_c.set_p;
            end else begin
                s1_exec    <= 1'b0;
            end
        end
    end

    // Architectural predicate and retired-instruction counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pred    <= 1'b0;
            retired <= '0;
        end else if (commit_c) begin
            if (s1_set_p) pred <= bus.alu_p;
            retired <= retired + DATA_W'(1);
        end
    end

endmodule

// File: tb/tb_sp_operand_fetch.sv
// Directed bench for sp_operand_fetch with the ALU stubbed by bench-driven alu_out/alu_p.
module tb_sp_operand_fetch;
    import sp_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        hold;
    logic        pred;
    logic [15:0] retired;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    always #5 clock = ~clock;

    sp_operand_fetch_if bus ();

    sp_operand_fetch dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (bus),
        .hold     (hold),
        .pred     (pred),
        .retired  (retired),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic instr_t mk(input op_t op, input reg_addr_t rd, input reg_addr_t ra,
                                  input reg_addr_t rb, input reg_addr_t rc, input logic set_p,
                                  input logic wr_en, input logic guard);
        instr_t i;
        i.op = op; i.rd = rd; i.ra = ra; i.rb = rb; i.rc = rc;
        i.rsvd = 1'b0; i.set_p = set_p; i.wr_en = wr_en; i.guard = guard;
        return i;
    endfunction

    task automatic send(input instr_t i);
        bus.in_instr = i;
        bus.in_valid = 1'b1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1; hold = 1'b0; dbg_addr = 4'd0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.alu_out = 16'h0; bus.alu_p = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_alu_a",    bus.alu_a, 16'h0);
        chk("rst_ex_valid", 16'(bus.ex_valid), 16'd0);
        chk("rst_retired",  retired, 16'h0);
        chk("rst_pred",     16'(pred), 16'd0);
        chk("in_ready_hold0", 16'(bus.in_ready), 16'd1);
        hold = 1'b1; #1;
        chk("in_ready_hold1", 16'(bus.in_ready), 16'd0);
        hold = 1'b0;
        #8 reset_n = 1'b1;

        // Dependency chain through forwarding
        send(mk(OP_ADD, 4'd1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0));
        tick();
        chk("i0_ex_valid", 16'(bus.ex_valid), 16'd1);
        chk("i0_alu_op",   16'(bus.alu_op), 16'(OP_ADD));
        bus.alu_out = 16'h0019;
        send(mk(OP_SUB, 4'd2, 4'd1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0));
        tick();
        chk("fwd_alu_a", bus.alu_a, 16'h0019);
        chk("fwd_alu_b", bus.alu_b, 16'h0019);
        chk("fwd_alu_c", bus.alu_c, 16'h0000);
        chk("i1_alu_op", 16'(bus.alu_op), 16'(OP_SUB));
        idle(); bus.alu_out = 16'hFFFF; dbg_addr = 4'd1; #1;
        chk("dbg_r1", dbg_data, 16'h0019);
        tick();
        chk("chain_retired", retired, 16'd2);
        chk("bubble_ex_valid", 16'(bus.ex_valid), 16'd0);
        chk("dbg_r1_nowr", dbg_data, 16'h0019);

        // r0 writes discarded and never forwarded
        send(mk(OP_ADD, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0));
        tick();
        bus.alu_out = 16'h1234;
        send(mk(OP_ADD, 4'd5, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0));
        tick();
        chk("r0_alu_a", bus.alu_a, 16'h0000);
        chk("rf_alu_b", bus.alu_b, 16'h0019);
        idle(); dbg_addr = 4'd0; #1;
        chk("dbg_r0", dbg_data, 16'h0000);
        tick();
        chk("r0_retired", retired, 16'd4);

        // Predicate forwarding and guarded squash
        send(mk(OP_CMP, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0));
        tick();
        bus.alu_p = 1'b0; bus.alu_out = 16'h0000;
        send(mk(OP_ADD, 4'd2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1));
        tick();
        chk("p0_pred",    16'(pred), 16'd0);
        chk("p0_retired", retired, 16'd5);
        bus.alu_out = 16'h5555; bus.alu_p = 1'b1;
        send(mk(OP_CMP, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0));
        tick();
        dbg_addr = 4'd2; #1;
        chk("squash_r2",      dbg_data, 16'h0000);
        chk("squash_retired", retired, 16'd5);
        chk("squash_pred",    16'(pred), 16'd0);
        send(mk(OP_ADD, 4'd2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1));
        tick();
        chk("p1_pred",    16'(pred), 16'd1);
        chk("p1_retired", retired, 16'd6);
        idle(); bus.alu_out = 16'h5555;
        tick();
        chk("guard_exec_r2",  dbg_data, 16'h5555);
        chk("guard_retired",  retired, 16'd7);

        // Hold freezes S1 and defers the commit
        send(mk(OP_ADD, 4'd3, 4'd2, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0));
        tick();
        chk("h_alu_a", bus.alu_a, 16'h5555);
        chk("h_alu_b", bus.alu_b, 16'h0019);
        chk("h_alu_c", bus.alu_c, 16'h5555);
        hold = 1'b1; bus.alu_out = 16'h0ABC;
        send(mk(OP_SUB, 4'd4, 4'd1, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0));
        dbg_addr = 4'd3; #1;
        chk("h_in_ready", 16'(bus.in_ready), 16'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("h_stable_a",  bus.alu_a, 16'h5555);
            chk("h_ex_valid",  16'(bus.ex_valid), 16'd1);
            chk("h_alu_op",    16'(bus.alu_op), 16'(OP_ADD));
            chk("h_retired",   retired, 16'd7);
            chk("h_no_write",  dbg_data, 16'h0000);
        end
        hold = 1'b0; idle();
        tick();
        chk("h_commit_r3",  dbg_data, 16'h0ABC);
        chk("h_retired1",   retired, 16'd8);
        chk("h_ex_valid0",  16'(bus.ex_valid), 16'd0);
        tick();
        chk("h_single_commit", retired, 16'd8);

        // Asynchronous reset while an instruction is in flight
        send(mk(OP_XOR, 4'd4, 4'd3, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0));
        tick();
        chk("m_ex_valid", 16'(bus.ex_valid), 16'd1);
        chk("m_alu_a",    bus.alu_a, 16'h0ABC);
        idle();
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_ex_valid", 16'(bus.ex_valid), 16'd0);
        chk("mrst_alu_a",    bus.alu_a, 16'h0000);
        chk("mrst_alu_op",   16'(bus.alu_op), 16'd0);
        chk("mrst_retired",  retired, 16'h0000);
        chk("mrst_pred",     16'(pred), 16'd0);
        reset_n = 1'b1;
        for (int r = 1; r < 16; r++) begin
            dbg_addr = 4'(r);
            #1;
            chk("mrst_rf_clear", dbg_data, 16'h0000);
        end

        // Retired counter wraps after 65536 executed instructions
        send(mk(OP_ADD, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        repeat (65535) tick();
        idle();
        tick();
        chk("wrap_ffff", retired, 16'hFFFF);
        send(mk(OP_ADD, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        tick();
        idle();
        tick();
        chk("wrap_zero", retired, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
